// File: rtl/window_frame_arbiter_pkg.sv
// Shared definitions for the frame arbiter: FSM encoding, minimum frame
// dimension and default field widths.
package window_frame_arbiter_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int SW_DEFAULT = 11;
  localparam int MIN_DIM    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/window_frame_arbiter_frame_counter.sv
// Raster (w,h) position counter for one frame; flags the final pixel.
module window_frame_arbiter_frame_counter
  import window_frame_arbiter_pkg::*;
#(
  parameter int SW = SW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          adv,
  input  logic [SW-1:0] width,
  input  logic [SW-1:0] height,
  output logic          last
);

  logic [SW-1:0] w_q, w_d;
  logic [SW-1:0] h_q, h_d;
  logic          w_wrap;

  // Next raster position: wrap the column at width-1 and step the row
  always_comb begin
    w_wrap = (w_q == width - SW'(1));
    last   = w_wrap && (h_q == height - SW'(1));
    w_d    = w_q;
    h_d    = h_q;
    if (clear) begin
      w_d = '0;
      h_d = '0;
    end else if (adv) begin
      if (w_wrap) begin
        w_d = '0;
        h_d = h_q + SW'(1);
      end else begin
        w_d = w_q + SW'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q <= '0;
      h_q <= '0;
    end else begin
      w_q <= w_d;
      h_q <= h_d;
    end
  end

endmodule

// File: rtl/window_frame_arbiter.sv
// Grants whole frames round-robin between two pixel streams, drives the
// window generator's size configuration and multiplexes the winner into it,
// holding the grant until the generator has emitted the frame's last pixel.
module window_frame_arbiter
  import window_frame_arbiter_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int SW = SW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [DW-1:0] s0_data,
  input  logic [SW-1:0] s0_width,
  input  logic [SW-1:0] s0_height,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [DW-1:0] s1_data,
  input  logic [SW-1:0] s1_width,
  input  logic [SW-1:0] s1_height,
  output logic [SW-1:0] win_width,
  output logic [SW-1:0] win_height,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [DW-1:0] win_data,
  input  logic          win_out_fire,
  output logic          grant_id,
  output logic          busy,
  output logic          size_err
);

  localparam int CW = 2 * SW;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic          grant_q, grant_d;
  logic          size_err_q, size_err_d;
  logic [SW-1:0] win_width_q, win_width_d;
  logic [SW-1:0] win_height_q, win_height_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          in_done_q, in_done_d;
  logic          out_done_q, out_done_d;

  logic          feed_open;
  logic          in_fire;
  logic          in_last;
  logic          out_fire_ok;
  logic          out_last;
  logic [SW-1:0] sel_width;
  logic [SW-1:0] sel_height;
  logic [CW-1:0] frame_pixels;

  assign sel_width    = grant_q ? s1_width  : s0_width;
  assign sel_height   = grant_q ? s1_height : s0_height;
  assign frame_pixels = {{SW{1'b0}}, win_width_q} * {{SW{1'b0}}, win_height_q};
  assign out_fire_ok  = win_out_fire && ((state_q == FEED) || (state_q == DRAIN));
  assign out_last     = out_fire_ok && (out_cnt_q == frame_pixels - CW'(1));

  assign win_width  = win_width_q;
  assign win_height = win_height_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);
  assign size_err   = size_err_q;

  // Zero-latency pass-through of the granted stream; everything else stalls
  always_comb begin
    feed_open = (state_q == FEED) && !in_done_q;
    win_valid = 1'b0;
    win_data  = '0;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    if (feed_open) begin
      if (grant_q) begin
        win_valid = s1_valid;
        win_data  = s1_data;
        s1_ready  = win_ready;
      end else begin
        win_valid = s0_valid;
        win_data  = s0_data;
        s0_ready  = win_ready;
      end
    end
    in_fire = win_valid && win_ready;
  end

  window_frame_arbiter_frame_counter #(.SW(SW)) u_in_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == LOAD),
    .adv    (in_fire),
    .width  (win_width_q),
    .height (win_height_q),
    .last   (in_last)
  );

  // Frame sequencing: arbitrate, load size, feed pixels, wait for output drain
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    size_err_d   = 1'b0;
    win_width_d  = win_width_q;
    win_height_d = win_height_q;
    out_cnt_d    = out_cnt_q;
    in_done_d    = in_done_q;
    out_done_d   = out_done_q;
    if (out_fire_ok) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end
    if (out_last) begin
      out_done_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          grant_d = (s0_valid && s1_valid) ? rr_q : s1_valid;
          state_d = LOAD;
        end
      end
      LOAD: begin
        win_width_d  = sel_width;
        win_height_d = sel_height;
        out_cnt_d    = '0;
        in_done_d    = 1'b0;
        out_done_d   = 1'b0;
        if ((sel_width >= SW'(MIN_DIM)) && (sel_height >= SW'(MIN_DIM))) begin
          state_d = FEED;
        end else begin
          size_err_d = 1'b1;
          rr_d       = ~grant_q;
          state_d    = IDLE;
        end
      end
      FEED: begin
        if (in_fire && in_last) begin
          in_done_d = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_done_q || out_last) begin
          rr_d    = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      grant_q      <= 1'b0;
      size_err_q   <= 1'b0;
      win_width_q  <= '0;
      win_height_q <= '0;
      out_cnt_q    <= '0;
      in_done_q    <= 1'b0;
      out_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      size_err_q   <= size_err_d;
      win_width_q  <= win_width_d;
      win_height_q <= win_height_d;
      out_cnt_q    <= out_cnt_d;
      in_done_q    <= in_done_d;
      out_done_q   <= out_done_d;
    end
  end

endmodule

// File: tb/tb_window_frame_arbiter.sv
// Scoreboard bench for window_frame_arbiter: a frame-level reference model
// predicts the ordered pixel stream and size errors; a monitor checks them.
module tb_window_frame_arbiter;

  localparam int DW = 8;
  localparam int SW = 11;

  logic          clk;
  logic          rst;
  logic          s0_valid, s0_ready, s1_valid, s1_ready;
  logic [DW-1:0] s0_data, s1_data, win_data;
  logic [SW-1:0] s0_width, s0_height, s1_width, s1_height;
  logic [SW-1:0] win_width, win_height;
  logic          win_valid, win_ready, win_out_fire;
  logic          grant_id, busy, size_err;

  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
    logic [SW-1:0] w;
    logic [SW-1:0] h;
  } exp_t;

  exp_t          exp_hs[$];
  logic          exp_err[$];
  int            exp_tot[$];
  logic [DW-1:0] pix0[$], pix1[$];
  int            w0[$], h0[$], w1[$], h1[$];
  int            pos0, pos1, pending, frame_fires, idle_wait;
  int            hs_total, fire_total, checks, errors;
  bit            run, gap_en, bp_en, zero_lag;
  logic          model_rr;

  window_frame_arbiter #(.DW(DW), .SW(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s0_valid     (s0_valid),
    .s0_ready     (s0_ready),
    .s0_data      (s0_data),
    .s0_width     (s0_width),
    .s0_height    (s0_height),
    .s1_valid     (s1_valid),
    .s1_ready     (s1_ready),
    .s1_data      (s1_data),
    .s1_width     (s1_width),
    .s1_height    (s1_height),
    .win_width    (win_width),
    .win_height   (win_height),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .win_data     (win_data),
    .win_out_fire (win_out_fire),
    .grant_id     (grant_id),
    .busy         (busy),
    .size_err     (size_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Queue one frame on a source; legal frames get random pixel content
  task automatic applyStimulus(input logic src, input int w, input int h);
    if (src) begin
      w1.push_back(w);
      h1.push_back(h);
    end else begin
      w0.push_back(w);
      h0.push_back(h);
    end
    if (w >= 2 && h >= 2) begin
      for (int i = 0; i < w * h; i++) begin
        if (src) pix1.push_back(DW'($urandom));
        else     pix0.push_back(DW'($urandom));
      end
    end
  endtask

  // Frame-level reference: round-robin over queued frames, whole frames at a time
  task automatic buildExpected(output int npix);
    int   mw0[$], mh0[$], mw1[$], mh1[$];
    int   p0, p1, fw, fh;
    logic pick;
    logic [DW-1:0] px;
    mw0 = w0; mh0 = h0; mw1 = w1; mh1 = h1;
    p0 = 0; p1 = 0; npix = 0;
    while (mw0.size() > 0 || mw1.size() > 0) begin
      if (mw0.size() > 0 && mw1.size() > 0) pick = model_rr;
      else pick = (mw1.size() > 0);
      if (pick) begin fw = mw1.pop_front(); fh = mh1.pop_front(); end
      else      begin fw = mw0.pop_front(); fh = mh0.pop_front(); end
      if (fw < 2 || fh < 2) begin
        exp_err.push_back(pick);
      end else begin
        for (int i = 0; i < fw * fh; i++) begin
          if (pick) begin px = pix1[p1]; p1++; end
          else      begin px = pix0[p0]; p0++; end
          exp_hs.push_back(exp_t'{pick, px, SW'(fw), SW'(fh)});
        end
        exp_tot.push_back(fw * fh);
        npix += fw * fh;
      end
      model_rr = !pick;
    end
  endtask

  // Stimulus driver: sources with optional gaps, backpressure, window-generator model
  always begin
    @(negedge clk);
    win_out_fire = 1'b0;
    if (!run) begin
      s0_valid  = 1'b0;
      s1_valid  = 1'b0;
      win_ready = 1'b1;
    end else begin
      if (size_err) begin
        if (grant_id && w1.size() > 0 && (w1[0] < 2 || h1[0] < 2)) begin
          void'(w1.pop_front()); void'(h1.pop_front());
        end else if (!grant_id && w0.size() > 0 && (w0[0] < 2 || h0[0] < 2)) begin
          void'(w0.pop_front()); void'(h0.pop_front());
        end
      end
      s0_valid  = (w0.size() > 0) && !(gap_en && pos0 > 0 && $urandom_range(0, 3) == 0);
      s1_valid  = (w1.size() > 0) && !(gap_en && pos1 > 0 && $urandom_range(0, 3) == 0);
      s0_width  = (w0.size() > 0) ? SW'(w0[0]) : '0;
      s0_height = (h0.size() > 0) ? SW'(h0[0]) : '0;
      s1_width  = (w1.size() > 0) ? SW'(w1[0]) : '0;
      s1_height = (h1.size() > 0) ? SW'(h1[0]) : '0;
      s0_data   = (w0.size() > 0 && w0[0] >= 2 && h0[0] >= 2 && pix0.size() > 0) ? pix0[0] : '0;
      s1_data   = (w1.size() > 0 && w1[0] >= 2 && h1[0] >= 2 && pix1.size() > 0) ? pix1[0] : '0;
      win_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!zero_lag && pending > 0 && $urandom_range(0, 2) != 0) begin
        win_out_fire = 1'b1;
        pending--;
      end
      #1;
      if (s0_valid && s0_ready && pix0.size() > 0) begin
        void'(pix0.pop_front());
        pos0++;
        if (pos0 == w0[0] * h0[0]) begin
          void'(w0.pop_front()); void'(h0.pop_front()); pos0 = 0;
        end
      end
      if (s1_valid && s1_ready && pix1.size() > 0) begin
        void'(pix1.pop_front());
        pos1++;
        if (pos1 == w1[0] * h1[0]) begin
          void'(w1.pop_front()); void'(h1.pop_front()); pos1 = 0;
        end
      end
      if (win_valid && win_ready) begin
        if (zero_lag) win_out_fire = 1'b1;
        else pending++;
      end
    end
  end

  // Monitor: pops the scoreboard on every DUT handshake, size error and frame end
  always begin : monitor
    exp_t x;
    logic e;
    @(negedge clk);
    #2;
    if (run) begin
      if (idle_wait > 0) begin
        idle_wait--;
        if (idle_wait == 0) checkOutput("idle_after_last_fire", int'(busy), 0);
        else checkOutput("drain_one_cycle_busy", int'(busy), 1);
      end
      if (size_err) begin
        if (exp_err.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL size_err_unexpected got pulse on src %0d required none", grant_id);
        end else begin
          e = exp_err.pop_front();
          checkOutput("size_err_src", int'(grant_id), int'(e));
        end
      end
      if (win_valid && win_ready) begin
        hs_total++;
        if (exp_hs.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL extra_pixel got data %0d required none", win_data);
        end else begin
          x = exp_hs.pop_front();
          checkOutput("grant_id", int'(grant_id), int'(x.src));
          checkOutput("win_data", int'(win_data), int'(x.data));
          checkOutput("win_width", int'(win_width), int'(x.w));
          checkOutput("win_height", int'(win_height), int'(x.h));
          checkOutput("other_ready", int'(x.src ? s0_ready : s1_ready), 0);
        end
      end
      if (win_out_fire) begin
        fire_total++;
        frame_fires++;
        if (exp_tot.size() > 0 && frame_fires == exp_tot[0]) begin
          void'(exp_tot.pop_front());
          frame_fires = 0;
          idle_wait   = (win_valid && win_ready) ? 2 : 1;
        end
      end
    end
  end

  task automatic clearBench();
    exp_hs.delete(); exp_err.delete(); exp_tot.delete();
    pix0.delete(); pix1.delete(); w0.delete(); h0.delete(); w1.delete(); h1.delete();
    pos0 = 0; pos1 = 0; pending = 0; frame_fires = 0; idle_wait = 0;
  endtask

  task automatic runScenario(input string name, input bit gaps, input bit bp, input bit zl);
    int  npix;
    bit  done;
    gap_en = gaps; bp_en = bp; zero_lag = zl;
    hs_total = 0; fire_total = 0;
    buildExpected(npix);
    run  = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      #3;
      done = (exp_hs.size() == 0) && (exp_err.size() == 0) && (exp_tot.size() == 0) &&
             (idle_wait == 0) && !busy && (w0.size() == 0) && (w1.size() == 0);
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL timeout_%s got %0d pixels pending required 0", name, exp_hs.size());
    end
    checkOutput({name, "_in_handshakes"}, hs_total, npix);
    checkOutput({name, "_out_fires"}, fire_total, npix);
    run = 1'b0;
    @(negedge clk);
    clearBench();
  endtask

  initial begin
    checks = 0; errors = 0; run = 1'b0; model_rr = 1'b0;
    gap_en = 1'b0; bp_en = 1'b0; zero_lag = 1'b0;
    hs_total = 0; fire_total = 0;
    clearBench();
    rst = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
    s0_width = '0; s0_height = '0; s1_width = '0; s1_height = '0;
    win_ready = 1'b1; win_out_fire = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_win_valid", int'(win_valid), 0);
    checkOutput("rst_s0_ready", int'(s0_ready), 0);
    checkOutput("rst_s1_ready", int'(s1_ready), 0);
    checkOutput("rst_win_width", int'(win_width), 0);
    checkOutput("rst_win_height", int'(win_height), 0);
    checkOutput("rst_win_data", int'(win_data), 0);
    checkOutput("rst_grant_id", int'(grant_id), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_size_err", int'(size_err), 0);
    @(negedge clk);
    #3 rst = 1'b0;

    $display("[TB] single source 4x3");
    applyStimulus(1'b0, 4, 3);
    runScenario("single_4x3", 1'b0, 1'b0, 1'b0);

    $display("[TB] rejected 1x8 frame on s1");
    applyStimulus(1'b1, 1, 8);
    runScenario("size_err_1x8", 1'b0, 1'b0, 1'b0);

    $display("[TB] both sources alternate");
    applyStimulus(1'b0, 5, 2); applyStimulus(1'b0, 5, 2);
    applyStimulus(1'b1, 3, 4); applyStimulus(1'b1, 3, 4);
    runScenario("alternate", 1'b0, 1'b0, 1'b0);

    $display("[TB] 6x6 with gaps and backpressure");
    applyStimulus(1'b0, 6, 6);
    runScenario("gaps_bp_6x6", 1'b1, 1'b1, 1'b0);

    $display("[TB] zero-lag window generator");
    applyStimulus(1'b0, 3, 3); applyStimulus(1'b1, 4, 2);
    runScenario("zero_lag", 1'b0, 1'b1, 1'b1);

    $display("[TB] random frame mix");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, $urandom_range(1, 5), $urandom_range(1, 5));
      applyStimulus(1'b1, $urandom_range(1, 5), $urandom_range(1, 5));
    end
    runScenario("random_mix", 1'b1, 1'b1, 1'b0);

    $display("[TB] reset in the middle of an 8x8 frame");
    begin
      int npix;
      gap_en = 1'b0; bp_en = 1'b1; zero_lag = 1'b0;
      hs_total = 0; fire_total = 0;
      applyStimulus(1'b0, 8, 8);
      buildExpected(npix);
      run = 1'b1;
      for (int c = 0; c < 1000 && hs_total < 20; c++) @(negedge clk);
      checkOutput("reached_mid_frame", int'(hs_total >= 20), 1);
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("midrst_win_valid", int'(win_valid), 0);
      checkOutput("midrst_s0_ready", int'(s0_ready), 0);
      checkOutput("midrst_win_width", int'(win_width), 0);
      checkOutput("midrst_win_height", int'(win_height), 0);
      checkOutput("midrst_win_data", int'(win_data), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      run = 1'b0;
      clearBench();
      model_rr = 1'b0;
      @(negedge clk);
      #3 rst = 1'b0;
    end

    $display("[TB] clean frame after reset");
    applyStimulus(1'b0, 3, 2); applyStimulus(1'b1, 2, 3);
    runScenario("after_reset", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
